// File: rtl/mmio_peripherals_pkg.sv
// Shared definitions for the MMIO peripheral block: register offsets,
// control/status layouts and the default window base.
package mmio_peripherals_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0000_1000;

  localparam logic [31:0] OFF_LED    = 32'h00;
  localparam logic [31:0] OFF_PHOTO  = 32'h04;
  localparam logic [31:0] OFF_TIMER  = 32'h08;
  localparam logic [31:0] OFF_CMP    = 32'h0C;
  localparam logic [31:0] OFF_CTRL   = 32'h10;
  localparam logic [31:0] OFF_STATUS = 32'h14;
  localparam logic [31:0] MMIO_SPAN  = 32'h18;

  localparam int CTRL_TIMER_EN_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int STATUS_MATCH_BIT  = 0;
  localparam int STATUS_EDGE_LSB   = 1;

  typedef struct packed {
    logic irq_en;
    logic timer_en;
  } ctrl_t;

  typedef struct packed {
    logic [1:0] photo_edge;
    logic       match;
  } status_t;

endpackage

// File: rtl/mmio_peripherals_photores_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer for one
// photoresistor bit; 'changed' is high on the edge that flips 'debounced'.
module photores_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic debounced,
  output logic changed
);

  localparam int COUNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(DEBOUNCE_CYCLES - 1);

  logic               sync_ff1;
  logic               sync_ff2;
  logic [COUNT_W-1:0] count;

  // Holding COUNT_LAST while still different means this edge is the
  // DEBOUNCE_CYCLES-th stable cycle, so the counter would reach the limit now.
  assign changed = (sync_ff2 != debounced) && (count == COUNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff1  <= 1'b0;
      sync_ff2  <= 1'b0;
      count     <= '0;
      debounced <= 1'b0;
    end else begin
      sync_ff1 <= raw;
      sync_ff2 <= sync_ff1;
      if (sync_ff2 == debounced) begin
        count <= '0;
      end else if (changed) begin
        debounced <= sync_ff2;
        count     <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_peripherals.sv
// MMIO slave holding the LED register, debounced photoresistor inputs and a
// free-running timer with compare/match interrupt.
module mmio_peripherals
  import mmio_peripherals_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = DEFAULT_BASE_ADDRESS,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          LED_WIDTH       = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  input  logic                 mem_write,
  input  logic                 mem_read,
  output logic                 ready,
  output logic [31:0]          read_data,
  output logic                 access_error,
  input  logic [1:0]           photores,
  output logic [LED_WIDTH-1:0] led,
  output logic                 timer_irq
);

  // Handshake: a request is any cycle with mem_read or mem_write high; ready
  // pulses exactly one cycle later with no back-pressure, read_data is valid
  // while ready is high, and a combined read+write performs only the write.
  logic [31:0]          offset;
  logic [31:0]          word_off;
  logic                 mapped;
  logic                 request;
  logic                 do_write;
  logic                 do_read;
  logic [2:0]           status_clear;
  logic [31:0]          read_value;
  logic [LED_WIDTH-1:0] led_q;
  logic [31:0]          timer_q;
  logic [31:0]          cmp_q;
  ctrl_t                ctrl_q;
  status_t              status_q;
  logic [1:0]           photo_deb;
  logic [1:0]           photo_change;

  // Addresses below the base wrap to huge offsets and fall out of the window.
  assign offset       = address - BASE_ADDRESS;
  assign word_off     = offset & 32'hFFFF_FFFC;
  assign mapped       = offset < MMIO_SPAN;
  assign request      = mem_read | mem_write;
  assign do_write     = mem_write & mapped;
  assign do_read      = mem_read & ~mem_write;
  assign status_clear = (do_write && word_off == OFF_STATUS) ? write_data[2:0] : 3'b000;

  for (genvar b = 0; b < 2; b++) begin : g_photo
    photores_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clock    (clock),
      .reset_n  (reset_n),
      .raw      (photores[b]),
      .debounced(photo_deb[b]),
      .changed  (photo_change[b])
    );
  end

  always_comb begin
    read_value = '0;
    case (word_off)
      OFF_LED:    read_value[LED_WIDTH-1:0] = led_q;
      OFF_PHOTO:  read_value[1:0]           = photo_deb;
      OFF_TIMER:  read_value                = timer_q;
      OFF_CMP:    read_value                = cmp_q;
      OFF_CTRL:   read_value[1:0]           = ctrl_q;
      OFF_STATUS: read_value[2:0]           = status_q;
      default:    read_value                = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready        <= 1'b0;
      read_data    <= '0;
      access_error <= 1'b0;
      led_q        <= '0;
      timer_q      <= '0;
      cmp_q        <= '0;
      ctrl_q       <= '0;
      status_q     <= '0;
    end else begin
      ready        <= request;
      access_error <= request & ~mapped;
      if (do_read) read_data <= read_value;

      if (do_write) begin
        case (word_off)
          OFF_LED:  led_q  <= write_data[LED_WIDTH-1:0];
          OFF_CMP:  cmp_q  <= write_data;
          OFF_CTRL: ctrl_q <= ctrl_t'(write_data[1:0]);
          default:  ;
        endcase
      end

      // A CPU load of the count takes priority over the increment.
      if (do_write && word_off == OFF_TIMER) timer_q <= write_data;
      else if (ctrl_q.timer_en)              timer_q <= timer_q + 32'd1;

      // Set events win over a simultaneous write-one-to-clear.
      status_q.match <= (status_q.match & ~status_clear[STATUS_MATCH_BIT])
                        | (timer_q == cmp_q);
      status_q.photo_edge <= (status_q.photo_edge & ~status_clear[STATUS_EDGE_LSB +: 2])
                             | photo_change;
    end
  end

  assign led       = ~led_q;
  assign timer_irq = status_q.match & ctrl_q.irq_en;

endmodule
